// File: rtl/riscv_pkg.sv
// Shared load-path definitions: funct3 load encodings, load FSM states,
// captured-request context and the access-legality helper.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} ld_state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] offset;
    logic [4:0] rd;
  } ld_ctx_t;

  // 1 when the load must be refused: illegal encoding or misaligned address.
  function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: ld_bad = 1'b0;
      F3_LH, F3_LHU: ld_bad = off[0];
      F3_LW:         ld_bad = (off != 2'b00);
      default:       ld_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane extraction and sign/zero extension of a little-endian read word.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [3:0][7:0] lanes;
  logic [7:0]      b;
  logic [15:0]     h;

  assign lanes = word;
  assign b     = lanes[offset];
  assign h     = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'd0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'd0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: one outstanding word read, lane extraction on response,
// single-cycle writeback or fault pulse.
module load_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  input  logic [4:0]        ld_rd,
  output logic              ld_busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic [4:0]        rd_out,
  output logic              ld_fault
);

  ld_state_e   state, state_nxt;
  ld_ctx_t     ctx;
  logic        err_q, fault_q;
  logic        take, bad;
  logic [31:0] aligned;

  assign bad  = ld_bad(ld_funct3, ld_addr[1:0]);
  assign take = (state == IDLE) && ld_req;

  always_comb begin
    state_nxt     = state;
    ld_busy       = 1'b1;
    mem_req_valid = 1'b0;
    ld_valid      = 1'b0;
    ld_fault      = fault_q;
    case (state)
      IDLE: begin
        ld_busy = 1'b0;
        if (take && !bad) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: if (mem_rsp_valid) state_nxt = DONE;
      DONE: begin
        ld_valid  = !err_q;
        ld_fault  = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Rejected requests never leave IDLE; fault_q gives them their one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx      <= '0;
      mem_addr <= '0;
      ld_data  <= '0;
      rd_out   <= '0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= take && bad;
      if (take) begin
        if (bad) rd_out <= ld_rd;
        else begin
          ctx      <= '{funct3: ld_funct3, offset: ld_addr[1:0], rd: ld_rd};
          mem_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
        end
      end
      if (state == WAIT && mem_rsp_valid) begin
        err_q   <= mem_rsp_err;
        ld_data <= mem_rsp_err ? 32'd0 : aligned;
        rd_out  <= ctx.rd;
      end
    end
  end

  load_align u_align (
    .word   (mem_rsp_data),
    .offset (ctx.offset),
    .funct3 (ctx.funct3),
    .data   (aligned)
  );

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: a configurable memory responder plus a
// writeback monitor that pops expected results as pulses appear.
module tb_load_unit;
  import riscv_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [2:0]        ld_funct3 = '0;
  logic [4:0]        ld_rd = '0;
  logic              ld_busy, mem_req_valid, ld_valid, ld_fault;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [31:0]       mem_rsp_data = '0;
  logic              mem_rsp_err = 1'b0;
  logic [31:0]       ld_data;
  logic [4:0]        rd_out;

  always #5 clk = ~clk;

  load_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd), .ld_busy(ld_busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .ld_valid(ld_valid), .ld_data(ld_data), .rd_out(rd_out), .ld_fault(ld_fault)
  );

  typedef struct {
    logic        fault;
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder
  int          ready_delay = 0, rsp_delay = 0, req_cnt = 0, rsp_wait = 0;
  logic        hs_pend = 1'b0, last_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_data = '0, exp_addr = '0;

  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (mem_req_ready && last_valid) begin
      hs_pend  = 1'b1;
      rsp_wait = rsp_delay;
    end
    if (hs_pend) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_data;
        mem_rsp_err   = rsp_err;
        hs_pend       = 1'b0;
      end else rsp_wait--;
    end
    if (mem_req_valid) begin
      chk("mem_addr", mem_addr, exp_addr);
      if (req_cnt >= ready_delay) mem_req_ready = 1'b1;
      else begin
        mem_req_ready = 1'b0;
        req_cnt++;
      end
    end else begin
      mem_req_ready = 1'b0;
      req_cnt       = 0;
    end
    last_valid = mem_req_valid;
  end

  // writeback monitor
  always @(negedge clk) begin
    if (ld_valid || ld_fault) begin
      if (sb.size() == 0) chk("unexpected_pulse", {30'd0, ld_valid, ld_fault}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ld_fault", 32'(ld_fault), 32'(e.fault));
        chk("ld_valid", 32'(ld_valid), 32'(!e.fault));
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        if (e.chk_data) chk("ld_data", ld_data, e.data);
        chk("latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic fault,
                      input logic chk_data, input int lat);
    exp_t x;
    x.fault = fault; x.data = data; x.chk_data = chk_data;
    x.rd = rd; x.start = cyc; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || ld_busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                       input logic [31:0] data, input logic fault, input logic chk_data,
                       input int lat);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
    exp_addr = addr & ~32'd3;
    push(rd, data, fault, chk_data, lat);
    @(negedge clk);
    ld_req = 1'b0;
    if (fault && lat == 1) begin
      for (int i = 0; i < 3; i++) begin
        chk("rej_busy", 32'(ld_busy), 32'd0);
        chk("rej_mreq", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
      end
    end
    wait_idle();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(ld_busy), 32'd0);
    chk({pfx, "_mreq"}, 32'(mem_req_valid), 32'd0);
    chk({pfx, "_valid"}, 32'(ld_valid), 32'd0);
    chk({pfx, "_fault"}, 32'(ld_fault), 32'd0);
    chk({pfx, "_data"}, ld_data, 32'd0);
    chk({pfx, "_rd"}, 32'(rd_out), 32'd0);
    chk({pfx, "_addr"}, mem_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // word load, minimum latency
    rsp_data = 32'hDEADBEEF;
    issue(F3_LW, 32'h100, 5'd1, 32'hDEADBEEF, 1'b0, 1'b1, 3);

    // lane extraction and extension
    rsp_data = 32'h80112233;
    issue(F3_LB,  32'h103, 5'd2, 32'hFFFFFF80, 1'b0, 1'b1, 3);
    issue(F3_LBU, 32'h103, 5'd3, 32'h00000080, 1'b0, 1'b1, 3);
    issue(F3_LHU, 32'h102, 5'd4, 32'h00008011, 1'b0, 1'b1, 3);
    issue(F3_LH,  32'h102, 5'd5, 32'hFFFF8011, 1'b0, 1'b1, 3);
    issue(F3_LB,  32'h100, 5'd6, 32'h00000033, 1'b0, 1'b1, 3);
    issue(F3_LH,  32'h100, 5'd7, 32'h00002233, 1'b0, 1'b1, 3);
    rsp_delay = 2;
    issue(F3_LW,  32'h104, 5'd8, 32'h80112233, 1'b0, 1'b1, 5);
    rsp_delay = 0; ready_delay = 1;
    issue(F3_LBU, 32'h101, 5'd9, 32'h00000022, 1'b0, 1'b1, 4);
    ready_delay = 0;

    // misaligned / illegal: immediate fault, no memory traffic
    issue(F3_LH,  32'h101, 5'd10, 32'd0, 1'b1, 1'b0, 1);
    issue(F3_LW,  32'h102, 5'd11, 32'd0, 1'b1, 1'b0, 1);
    issue(3'b011, 32'h100, 5'd12, 32'd0, 1'b1, 1'b0, 1);
    issue(3'b110, 32'h100, 5'd16, 32'd0, 1'b1, 1'b0, 1);
    issue(3'b111, 32'h100, 5'd17, 32'd0, 1'b1, 1'b0, 1);

    // ready stalls 4 cycles, bus error on response
    ready_delay = 4; rsp_err = 1'b1;
    issue(F3_LW, 32'h200, 5'd13, 32'd0, 1'b1, 1'b1, 7);
    ready_delay = 0; rsp_err = 1'b0;

    // request held while busy is served afterwards with its own tag
    rsp_delay = 1; rsp_data = 32'h12345678;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h300; ld_funct3 = F3_LW; ld_rd = 5'd14;
    exp_addr = 32'h300;
    push(5'd14, 32'h12345678, 1'b0, 1'b1, 4);
    @(negedge clk);
    chk("held_busy", 32'(ld_busy), 32'd1);
    ld_addr = 32'h304; ld_rd = 5'd15;
    for (int i = 0; i < 30 && ld_busy; i++) @(negedge clk);
    chk("held_idle", 32'(ld_busy), 32'd0);
    exp_addr = 32'h304;
    push(5'd15, 32'h12345678, 1'b0, 1'b1, 4);
    @(negedge clk);
    ld_req = 1'b0;
    wait_idle();

    // reset during WAIT; late response must be dropped
    rsp_delay = 4; rsp_data = 32'hCAFEF00D;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h400; ld_funct3 = F3_LW; ld_rd = 5'd20;
    exp_addr = 32'h400;
    @(negedge clk);
    ld_req = 1'b0;
    @(negedge clk);
    chk("wait_busy", 32'(ld_busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_busy", 32'(ld_busy), 32'd0);
      chk("postrst_data", ld_data, 32'd0);
      chk("postrst_rd", 32'(rd_out), 32'd0);
    end

    // recovery
    rsp_delay = 0; rsp_data = 32'hA5A5_7F01;
    issue(F3_LB, 32'h501, 5'd21, 32'h0000007F, 1'b0, 1'b1, 3);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter: ADDR_W, 32, data-memory byte-address width.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: ld_req  in  1  MEM stage requests a load this cycle.
REQ-005 Port: ld_addr  in  ADDR_W  byte address of the load.
REQ-006 Port: ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-007 Port: ld_rd  in  5  destination register tag.
REQ-008 Port: ld_busy  out  1  unit occupied; pipeline stalls MEM.
REQ-009 Port: mem_req_valid  out  1  read request to data memory.
REQ-010 Port: mem_req_ready  in  1  memory accepts request.
REQ-011 Port: mem_addr  out  ADDR_W  word-aligned read address, bits [1:0] forced 0.
REQ-012 Port: mem_rsp_valid  in  1  read data valid.
REQ-013 Port: mem_rsp_data  in  32  read word, little-endian.
REQ-014 Port: mem_rsp_err  in  1  bus error qualifying mem_rsp_valid.
REQ-015 Port: ld_valid  out  1  one-cycle pulse: ld_data/rd_out valid for writeback.
REQ-016 Port: ld_data  out  32  extracted, extended load value (writeback load-data input).
REQ-017 Port: rd_out  out  5  destination tag accompanying ld_valid/ld_fault.
REQ-018 Port: ld_fault  out  1  one-cycle pulse: misaligned, illegal funct3, or bus error.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; ld_busy SHALL be 1 in every state except IDLE.
REQ-020 IDLE with ld_req=1 and legal aligned access: capture addr, funct3, rd; go to REQ.
REQ-021 Misaligned = LH/LHU with addr[0]=1, or LW with addr[1:0]!=0; illegal = funct3 in {011,110,111}; either SHALL stay IDLE and pulse ld_fault with rd_out=ld_rd next cycle, no memory request.
REQ-022 REQ: mem_req_valid=1, mem_addr held stable until mem_req_ready=1, then go to WAIT.
REQ-023 WAIT: on mem_rsp_valid=1 register extracted data and go to DONE; mem_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-024 Extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-025 DONE: exactly one cycle; ld_valid=1 (or ld_fault=1 with ld_data=0 if the response had mem_rsp_err=1); return to IDLE.
REQ-026 ld_req while ld_busy=1 SHALL be ignored; requester holds it until ld_busy falls.
REQ-027 Minimum latency, accept to ld_valid: 3 cycles (ready and response each in first eligible cycle); memory wait states add 1:1.
REQ-028 ld_data and rd_out SHALL hold their last value outside ld_valid pulses.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, mem_req_valid=0, ld_valid=0, ld_fault=0, ld_busy=0, ld_data=0, rd_out=0, mem_addr=0.
REQ-030 Reset during REQ or WAIT SHALL abandon the transaction; a response arriving after release SHALL be ignored.

Structure
REQ-031 Load funct3 encodings and the FSM state encoding SHALL live in the shared package riscv_pkg.
REQ-032 Lane extraction and extension SHALL be a combinational sub-module load_align; load_unit holds only FSM and registers.

Verification
REQ-033 LW addr 0x100, ready and rsp immediate, data 0xDEADBEEF -> ld_valid 3 cycles after accept, ld_data 0xDEADBEEF, mem_addr 0x100.
REQ-034 LB addr 0x103, data 0x80112233 -> ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-035 LH addr 0x101 -> ld_fault next cycle, mem_req_valid never asserted, ld_busy stays 0.
REQ-036 mem_req_ready low 4 cycles then rsp_err=1 -> mem_addr stable throughout, ld_fault pulse, ld_data 0, ld_valid never 1.
REQ-037 rst_n low while in WAIT, then rsp_valid after release -> all outputs 0, state IDLE, no ld_valid.
REQ-038 Second ld_req while busy -> ignored until ld_busy=0, then served with its own rd tag.
